vga_timing_ctrl: RTL
====================

VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 SHALL have parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 SHALL have parameter H_FP, 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 96, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, 48, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, 10, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 2, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, 33, vertical back porch in lines.
REQ-009 SHALL have port clk, input, 1, 50 MHz system clock; all logic rising-edge.
REQ-010 SHALL have port rst_n, input, 1; one clock; reset is synchronous and active-low.
REQ-011 SHALL have port x, output, 10, horizontal pixel counter that feeds the pixel generator.
REQ-012 SHALL have port y, output, 10, vertical line counter that feeds the pixel generator.
REQ-013 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-014 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-015 SHALL have port blank_n, output, 1, high inside the visible area.
REQ-016 SHALL have port vga_clk, output, 1, 25 MHz pixel clock to the DAC.
REQ-017 SHALL have port pix_en, output, 1, one-clk pixel-tick strobe.
REQ-018 SHALL have port frame_start, output, 1, one-clk pulse at the start of each frame.

Function
REQ-019 SHALL toggle an internal divider every clk; pix_en = 1 on every second clk; vga_clk = registered divider bit, high during pix_en cycles.
REQ-020 SHALL advance counters only on pix_en cycles; x increments by 1, and wraps H_TOTAL-1 -> 0 (H_TOTAL = sum of H_* = 800).
REQ-021 SHALL increment y only on the x wrap; y wraps V_TOTAL-1 -> 0 (V_TOTAL = 525); x and y wrap on the same tick at (799,524).
REQ-022 SHALL register hsync, vsync and blank_n from the next counter values, so they align with x and y on the same cycle (zero relative latency).
REQ-023 SHALL drive hsync = 0 iff H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC (656..751 by default).
REQ-024 SHALL drive vsync = 0 iff V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC (490..491 by default).
REQ-025 SHALL drive blank_n = 1 iff x < H_ACTIVE and y < V_ACTIVE.
REQ-026 SHALL pulse frame_start for exactly one clk: the clk whose pix_en tick moves the counters to (0,0).
REQ-027 SHALL hold all outputs stable between pix_en ticks, except vga_clk and pix_en.

Reset
REQ-028 SHALL, while rst_n = 0 at a clk edge, load x = 0, y = 0, divider = 0, hsync = 1, vsync = 1, blank_n = 1, vga_clk = 0, pix_en = 0 and frame_start = 0.
REQ-029 SHALL produce the first pix_en on the second clk after rst_n rises; x becomes 1 on that tick.
REQ-030 SHALL, on reset asserted mid-frame, abandon the frame immediately; no frame_start is issued for the aborted frame.

Configuration
REQ-031 SHALL, with VGA_TIMING_FRAME_CNT_EN defined, add output frame_cnt[7:0]: reset 0, +1 in the frame_start cycle, wraps 255 -> 0.
REQ-032 SHALL, without VGA_TIMING_FRAME_CNT_EN, omit the frame_cnt port and its register entirely.

Verification
REQ-033 SHALL check: reset 3 clks, then release -> x=0, y=0, hsync=1, vsync=1, blank_n=1 during reset; pix_en on 2nd clk after release with x=1.
REQ-034 SHALL check: run one line -> hsync falls when x=656 and rises when x=752; blank_n falls when x=640; line = 1600 clk.
REQ-035 SHALL check: run one frame -> vsync low for y=490..491 only; frame_start pulses once every 840000 clk, in the cycle that moves (799,524) -> (0,0).
REQ-036 SHALL check: assert rst_n=0 at x=300, y=200 -> next cycle x=0, y=0, hsync=1, vsync=1, no frame_start.
REQ-037 SHALL check, with VGA_TIMING_FRAME_CNT_EN: run 256 frames -> frame_cnt goes 0..255 and then reads 0.

Source files
------------

// File: rtl/vga_timing_ctrl.sv
// VGA timing generator: pixel tick every second clk, x/y counters, sync/blank and frame_start; frame_cnt output only with VGA_TIMING_FRAME_CNT_EN.
// All outputs registered and aligned with x/y (zero relative latency); free-running, no backpressure.
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       vga_clk,
  output logic       pix_en,
  output logic       frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [7:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT      = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic       r_div;
  logic [9:0] r_x;
  logic [9:0] r_y;
  logic       r_hsync;
  logic       r_vsync;
  logic       r_blank_n;
  logic       r_vga_clk;
  logic       r_pix_en;
  logic       r_frame_start;

  logic       w_tick;
  logic       w_x_wrap;
  logic       w_y_wrap;
  logic [9:0] w_x_nxt;
  logic [9:0] w_y_nxt;
  logic       w_frame_start;

  // The divider is 1 on the clk edge that performs the pixel tick, so the
  // pix_en/vga_clk-high cycle is the one that shows the new counter values.
  always_comb begin
    w_tick        = r_div;
    w_x_wrap      = (r_x == H_LAST);
    w_y_wrap      = (r_y == V_LAST);
    w_x_nxt       = r_x;
    w_y_nxt       = r_y;
    w_frame_start = 1'b0;
    if (w_tick) begin
      w_x_nxt = w_x_wrap ? 10'd0 : r_x + 10'd1;
      if (w_x_wrap) begin
        w_y_nxt = w_y_wrap ? 10'd0 : r_y + 10'd1;
      end
      w_frame_start = w_x_wrap & w_y_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div         <= 1'b0;
      r_x           <= 10'd0;
      r_y           <= 10'd0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_blank_n     <= 1'b1;
      r_vga_clk     <= 1'b0;
      r_pix_en      <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_div         <= ~r_div;
      r_x           <= w_x_nxt;
      r_y           <= w_y_nxt;
      r_hsync       <= ~((w_x_nxt >= H_SYNC_BEG) && (w_x_nxt < H_SYNC_END));
      r_vsync       <= ~((w_y_nxt >= V_SYNC_BEG) && (w_y_nxt < V_SYNC_END));
      r_blank_n     <= (w_x_nxt < H_ACT) && (w_y_nxt < V_ACT);
      r_vga_clk     <= w_tick;
      r_pix_en      <= w_tick;
      r_frame_start <= w_frame_start;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign blank_n     = r_blank_n;
  assign vga_clk     = r_vga_clk;
  assign pix_en      = r_pix_en;
  assign frame_start = r_frame_start;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] r_frame_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_frame_cnt <= 8'd0;
    end else if (w_frame_start) begin
      r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end

  assign frame_cnt = r_frame_cnt;
`endif

endmodule
